grid_renderer: RTL
==================

Name: grid_renderer

Overview:
- Reader side of the 160x120 bullet shift grid: walks the flattened grid bit vector one pixel per clock and emits (x, y, colour, plot) for the VGA adapter.
- Overlays the player ship and enemy ship sprites on top of the bullet bits.
- Started once per frame, after the grid update, by the game control FSM.
- Reports busy/done so the controller can hold off the next grid update until the frame is fully drawn.

Parameters:
- WIDTH, 160, grid columns (x range 0..WIDTH-1).
- HEIGHT, 120, bits per column (y range 0..HEIGHT-1).
- SHIP_HALF, 2, sprite half-width; each sprite spans x_pos-SHIP_HALF..x_pos+SHIP_HALF.
- SHIP_ROWS, 4, sprite height in rows.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- grid  in  WIDTH*HEIGHT  flattened grid; bit 120*x+y is the bullet at (x,y).
- user_x  in  8  player column.
- enemy_x  in  8  enemy column.
- x  out  8  pixel column to the VGA adapter.
- y  out  7  pixel row to the VGA adapter.
- colour  out  3  pixel colour {R,G,B}.
- plot  out  1  pixel write strobe.
- busy  out  1  high from the cycle after start is accepted until the last pixel is emitted.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is named clock, reset port is named reset.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE. Reset during SCAN aborts the frame; no further plot pulses are emitted.
- States:
  - IDLE: start=1 latches user_x/enemy_x into internal registers, clears the scan counters, and goes to SCAN.
  - SCAN: emits one pixel per cycle. After pixel (WIDTH-1, HEIGHT-1) it goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start outside IDLE is ignored (no restart, no queuing). start in the DONE cycle is ignored.
- Scan order is column-major: y increments 0..HEIGHT-1 inside, x increments 0..WIDTH-1 outside. 19200 pixels with default parameters.
- All outputs are registered. If start is accepted at cycle n, pixel (0,0) appears with plot=1 at cycle n+1 and the last pixel at cycle n+19200; done is high at cycle n+19201.
- plot=1 on every SCAN output cycle, 0 otherwise. busy equals plot.
- The grid is sampled live at the current scan coordinate. The controller must hold the grid stable (gridUpdateEn low) while busy=1.
- Colour priority, evaluated per pixel:
  1. Player ship, green 3'b010: y >= HEIGHT-SHIP_ROWS and |x-user_x_l| <= SHIP_HALF.
  2. Enemy ship, red 3'b100: y < SHIP_ROWS and |x-enemy_x_l| <= SHIP_HALF.
  3. Bullet, white 3'b111: grid bit set.
  4. Otherwise black 3'b000.
- Distance compares use 9-bit signed arithmetic, with no wrap-around:
  - user_x=0 draws only columns 0..2.
  - user_x=159 draws only columns 157..159.
  - Positions >= WIDTH+SHIP_HALF draw nothing.
- user_x/enemy_x changes mid-frame have no effect until the next start.

Test Plan:
- Reset, grid all zero, user_x=80, enemy_x=20, pulse start -> exactly 19200 plot cycles, first (0,0) black one cycle after start. Green at x=78..82, y=116..119 (20 pixels). Red at x=18..22, y=0..3 (20 pixels). All else black. done pulses once at cycle 19201.
- Grid bit 120*10+50 set, others zero, ships at 80/20 -> pixel (10,50) is 3'b111 and is the only white pixel. Bits under a ship sprite render as the ship colour, not white.
- user_x=0, enemy_x=159 -> green only at x=0..2, red only at x=157..159, no wrapped pixels at the opposite edge. user_x=200 -> no green pixels.
- start re-pulsed at scan pixel 5000 and user_x changed mid-frame -> scan continues unchanged, single done, sprite positions match the values latched at start.
- Reset asserted at pixel 3000 -> plot, busy and done are 0 the next cycle and stay 0. A new start then restarts at (0,0).
- Back-to-back frames with start held high continuously -> a new frame begins the cycle after IDLE is re-entered, not during DONE. Pixel ordering and counts match the first test.

Source files
------------

// File: rtl/grid_renderer_if.sv
// Renderer bus: frame request, grid/sprite inputs and the pixel stream
// toward the VGA adapter, with done/busy status back to the controller.
interface grid_renderer_if #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
);
    logic                      start;
    logic [WIDTH*HEIGHT-1:0]   grid;
    logic [7:0]                user_x;
    logic [7:0]                enemy_x;
    logic [7:0]                x;
    logic [6:0]                y;
    logic [2:0]                colour;
    logic                      plot;
    logic                      busy;
    logic                      done;

    modport master (
        output start, grid, user_x, enemy_x,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, grid, user_x, enemy_x,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/grid_renderer.sv
// Column-major reader of the bullet grid, one pixel per clock, with the
// player and enemy ship sprites drawn over the bullet bits.
module grid_renderer #(
    parameter int WIDTH     = 160,
    parameter int HEIGHT    = 120,
    parameter int SHIP_HALF = 2,
    parameter int SHIP_ROWS = 4
) (
    input  logic            clock,
    input  logic            reset,
    grid_renderer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int               IW      = $clog2(WIDTH * HEIGHT);
    localparam logic [7:0]       X_LAST  = 8'(WIDTH - 1);
    localparam logic [6:0]       Y_LAST  = 7'(HEIGHT - 1);
    localparam logic [6:0]       Y_SHIP  = 7'(HEIGHT - SHIP_ROWS);
    localparam logic [6:0]       Y_ENEMY = 7'(SHIP_ROWS);
    localparam logic signed [8:0] HALF   = 9'(SHIP_HALF);

    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_WHITE = 3'b111;
    localparam logic [2:0] C_BLACK = 3'b000;

    state_t      state_q, state_d;
    logic [7:0]  ux_q, ux_d;
    logic [7:0]  ex_q, ex_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        done_q, done_d;

    // Coordinate and sprite positions of the pixel being registered now
    logic [7:0]  nx;
    logic [6:0]  ny;
    logic [7:0]  pu;
    logic [7:0]  pe;
    logic        emit;
    logic        last_px;

    logic signed [8:0] du;
    logic signed [8:0] de;
    logic        in_user;
    logic        in_enemy;
    logic        bullet;
    logic [IW-1:0] gidx;
    logic [2:0]  pix_col;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    // Frame sequencing and next scan coordinate
    always_comb begin
        state_d = state_q;
        ux_d    = ux_q;
        ex_d    = ex_q;
        nx      = x_q;
        ny      = y_q;
        pu      = ux_q;
        pe      = ex_q;
        emit    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    ux_d    = bus.user_x;
                    ex_d    = bus.enemy_x;
                    pu      = bus.user_x;
                    pe      = bus.enemy_x;
                    nx      = 8'd0;
                    ny      = 7'd0;
                    emit    = 1'b1;
                end
            end
            SCAN: begin
                if (last_px) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    emit = 1'b1;
                    if (y_q == Y_LAST) begin
                        nx = x_q + 8'd1;
                        ny = 7'd0;
                    end else begin
                        ny = y_q + 7'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sprite hit tests and colour priority for the selected pixel
    always_comb begin
        du       = $signed({1'b0, nx}) - $signed({1'b0, pu});
        de       = $signed({1'b0, nx}) - $signed({1'b0, pe});
        in_user  = (ny >= Y_SHIP) && (du >= -HALF) && (du <= HALF);
        in_enemy = (ny < Y_ENEMY) && (de >= -HALF) && (de <= HALF);
        gidx     = IW'(nx) * IW'(HEIGHT) + IW'(ny);
        bullet   = bus.grid[gidx];
        pix_col  = C_BLACK;
        if (in_user) begin
            pix_col = C_GREEN;
        end else if (in_enemy) begin
            pix_col = C_RED;
        end else if (bullet) begin
            pix_col = C_WHITE;
        end
    end

    // Output register inputs: only scan cycles drive a pixel
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = C_BLACK;
        plot_d   = 1'b0;
        if (emit) begin
            x_d      = nx;
            y_d      = ny;
            colour_d = pix_col;
            plot_d   = 1'b1;
        end
    end

    // State, latched sprite positions and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ux_q     <= 8'd0;
            ex_q     <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= C_BLACK;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ux_q     <= ux_d;
            ex_q     <= ex_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = plot_q;
    assign bus.done   = done_q;
endmodule
